// File: rtl/slap_io_pkg.sv
// Shared definitions for the hps_io ioctl helper blocks: upload FSM states,
// ioctl index constants and a counter-width helper.
package slap_io_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    ISSUE = 3'd2,
    LAT   = 3'd3,
    DONE  = 3'd4
  } upload_state_t;

  localparam logic [7:0] IDX_ROM    = 8'd0;
  localparam logic [7:0] IDX_MOD    = 8'd1;
  localparam logic [7:0] IDX_UPLOAD = 8'd2;
  localparam logic [7:0] IDX_DIP    = 8'd254;

  // Width needed to hold READ_LAT-1; never less than one bit.
  function automatic int lat_cnt_w(input int lat);
    return (lat <= 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/rd_lat_counter.sv
// Loadable down-counter with a zero flag; it stops at zero and holds there.
module rd_lat_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ioctl_upload_server.sv
// Serves HPS upload reads: fetches one byte per ioctl_rd from a core memory
// port while holding the core CPU paused, stalling the HPS with ioctl_wait.
module ioctl_upload_server
  import slap_io_pkg::*;
#(
  parameter logic [7:0]  INDEX    = IDX_UPLOAD,
  parameter int          ADDR_W   = 16,
  parameter int unsigned LENGTH   = 32'h1000,
  parameter logic [7:0]  FILL     = 8'hFF,
  parameter int          READ_LAT = 2
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              pause_req,
  input  logic              pause_ack,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              overrun,
  output logic [2:0]        o_dbg_state
);

  localparam int CNT_W = lat_cnt_w(READ_LAT);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LAT - 1);

  // HPS handshake: a one-cycle ioctl_rd is accepted only in IDLE; ioctl_wait
  // rises the next cycle and ioctl_din is valid in the first cycle it is low.
  upload_state_t     r_state;
  upload_state_t     w_state_nx;
  logic              w_sel;
  logic              w_oor;
  logic              w_accept;
  logic              w_load;
  logic              w_zero;
  logic              w_capture;
  logic              r_sel;
  logic              r_busy;
  logic              r_mem_rd;
  logic              r_pause;
  logic              r_wait;
  logic              r_overrun;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_din;

  assign w_sel     = ioctl_upload & (ioctl_index == INDEX);
  assign w_oor     = (32'(ioctl_addr) >= LENGTH);
  assign w_accept  = (r_state == IDLE) & w_sel & ioctl_rd;
  assign w_load    = (r_state == ISSUE);
  assign w_capture = (r_state == LAT) & w_zero & w_sel;

  // Runs independently of the FSM so an aborted read still times out and
  // releases pause_req only once the memory port is quiet.
  rd_lat_counter #(
    .W (CNT_W)
  ) u_lat_cnt (
    .clk        (clk_sys),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (LAT_LOAD),
    .i_dec      (r_busy),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    if (!w_sel && (r_state != IDLE)) begin
      w_state_nx = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (ioctl_rd && w_sel) w_state_nx = w_oor ? DONE : GRANT;
        GRANT:   if (pause_ack) w_state_nx = ISSUE;
        ISSUE:   w_state_nx = LAT;
        LAT:     if (w_zero) w_state_nx = DONE;
        DONE:    w_state_nx = IDLE;
        default: w_state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_sel     <= 1'b0;
      r_busy    <= 1'b0;
      r_mem_rd  <= 1'b0;
      r_pause   <= 1'b0;
      r_wait    <= 1'b0;
      r_overrun <= 1'b0;
      r_addr    <= '0;
      r_din     <= 8'h00;
    end else begin
      r_sel    <= w_sel;
      r_mem_rd <= (w_state_nx == ISSUE);
      r_pause  <= w_sel | w_load | (r_busy & ~w_zero);

      if (w_load) begin
        r_busy <= 1'b1;
      end else if (r_busy && w_zero) begin
        r_busy <= 1'b0;
      end

      if (w_accept) begin
        r_addr <= ioctl_addr[ADDR_W-1:0];
      end

      if (w_accept && w_oor) begin
        r_din <= FILL;
      end else if (w_capture) begin
        r_din <= mem_rdata;
      end

      if (w_accept) begin
        r_wait <= 1'b1;
      end else if (!w_sel || (r_state == DONE) || w_capture) begin
        r_wait <= 1'b0;
      end

      if (w_sel && !r_sel) begin
        r_overrun <= 1'b0;
      end else if (ioctl_rd && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign ioctl_din   = r_din;
  assign ioctl_wait  = r_wait;
  assign pause_req   = r_pause;
  assign mem_rd      = r_mem_rd;
  assign mem_addr    = r_addr;
  assign overrun     = r_overrun;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ioctl_upload_server.sv
// Directed bench for ioctl_upload_server with a latency-accurate memory model
// and a scoreboard monitor for memory strobes and completed uploads.
module tb_ioctl_upload_server;
  import slap_io_pkg::*;

  localparam int RL = 2;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        pause_req;
  logic        pause_ack;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        overrun;
  logic [2:0]  o_dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mrd_count = 0;
  int t, k, c0;
  logic abort_ok = 1'b0;

  logic [7:0]  exp_q[$];
  int          exp_wlen_q[$];
  logic [15:0] exp_maddr_q[$];
  int          exp_mcyc_q[$];

  ioctl_upload_server #(
    .INDEX    (8'd2),
    .ADDR_W   (16),
    .LENGTH   (32'h1000),
    .FILL     (8'hFF),
    .READ_LAT (RL)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .pause_req    (pause_req),
    .pause_ack    (pause_ack),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .overrun      (overrun),
    .o_dbg_state  (o_dbg_state)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // memory model: data valid exactly RL cycles after mem_rd, junk otherwise
  logic [7:0] mem [0:4095];
  logic [7:0] pd0, pd1, pd2, pd3;
  logic [3:0] pv = 4'b0000;

  always @(posedge clk_sys) begin
    pv  <= {pv[2:0], mem_rd};
    pd0 <= mem[mem_addr[11:0]];
    pd1 <= pd0;
    pd2 <= pd1;
    pd3 <= pd2;
  end

  assign mem_rdata = !pv[RL-1] ? 8'hC3 :
                     (RL == 1) ? pd0 : (RL == 2) ? pd1 : (RL == 3) ? pd2 : pd3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // monitor / scoreboard
  logic prev_wait = 1'b0;
  int   wlen = 0;

  always @(negedge clk_sys) begin
    if (reset) begin
      prev_wait = 1'b0;
      wlen = 0;
    end else begin
      if (mem_rd) begin
        mrd_count++;
        if (exp_maddr_q.size() == 0) begin
          fail("mem_rd_unexpected");
        end else begin
          chk("mem_addr", 32'(mem_addr), 32'(exp_maddr_q.pop_front()));
          chk("mem_rd_cycle", 32'(cyc), 32'(exp_mcyc_q.pop_front()));
        end
      end
      if (ioctl_wait) wlen++;
      if (prev_wait && !ioctl_wait) begin
        if (exp_q.size() != 0) begin
          chk("ioctl_din", 32'(ioctl_din), 32'(exp_q.pop_front()));
          chk("wait_len", 32'(wlen), 32'(exp_wlen_q.pop_front()));
        end else if (!abort_ok) begin
          fail("completion_unexpected");
        end
        abort_ok = 1'b0;
        wlen = 0;
      end
      prev_wait = ioctl_wait;
    end
  end

  // driver tasks
  task automatic do_rd(input logic [24:0] addr, output int tt);
    @(negedge clk_sys);
    ioctl_rd   = 1'b1;
    ioctl_addr = addr;
    tt         = cyc;
    @(negedge clk_sys);
    ioctl_rd   = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || exp_maddr_q.size() != 0) && n < max) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= max) fail("drain_timeout");
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_din"},      32'(ioctl_din),   32'h0);
    chk({tag, "_wait"},     32'(ioctl_wait),  32'h0);
    chk({tag, "_pause"},    32'(pause_req),   32'h0);
    chk({tag, "_mem_rd"},   32'(mem_rd),      32'h0);
    chk({tag, "_mem_addr"}, 32'(mem_addr),    32'h0);
    chk({tag, "_overrun"},  32'(overrun),     32'h0);
    chk({tag, "_state"},    32'(o_dbg_state), 32'(IDLE));
  endtask

  initial begin
    reset = 1'b1; ioctl_upload = 1'b0; ioctl_index = 8'd0;
    ioctl_rd = 1'b0; ioctl_addr = '0; pause_ack = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[12'h010] = 8'hA5; mem[12'hFFF] = 8'h3C; mem[12'h020] = 8'h77;
    mem[12'h030] = 8'h96; mem[12'h040] = 8'h5E; mem[12'h050] = 8'h22;
    mem[12'h060] = 8'h11;
    repeat (3) @(negedge clk_sys);
    chk_reset_vals("reset");
    reset = 1'b0;

    // session opens, CPU already halted
    ioctl_upload = 1'b1; ioctl_index = 8'd2; pause_ack = 1'b1;
    repeat (2) @(negedge clk_sys);
    chk("pause_req_on", 32'(pause_req), 32'h1);

    // in-range reads: mem_rd at T+2, wait high 4 cycles
    do_rd(25'h0010, t);
    exp_q.push_back(8'hA5); exp_wlen_q.push_back(4);
    exp_maddr_q.push_back(16'h0010); exp_mcyc_q.push_back(t + 2);
    wait_drain(40);
    do_rd(25'h0FFF, t);
    exp_q.push_back(8'h3C); exp_wlen_q.push_back(4);
    exp_maddr_q.push_back(16'h0FFF); exp_mcyc_q.push_back(t + 2);
    wait_drain(40);

    // out-of-range reads return FILL after a single wait cycle
    do_rd(25'h0001000, t);
    exp_q.push_back(8'hFF); exp_wlen_q.push_back(1);
    wait_drain(40);
    do_rd(25'h0020, t);
    exp_q.push_back(8'h77); exp_wlen_q.push_back(4);
    exp_maddr_q.push_back(16'h0020); exp_mcyc_q.push_back(t + 2);
    wait_drain(40);
    do_rd(25'h0010000, t);
    exp_q.push_back(8'hFF); exp_wlen_q.push_back(1);
    wait_drain(40);

    // a strobe for another index is ignored
    ioctl_index = 8'd0;
    do_rd(25'h0010, t);
    chk("other_index_wait", 32'(ioctl_wait), 32'h0);
    chk("other_index_state", 32'(o_dbg_state), 32'(IDLE));
    ioctl_index = 8'd2;
    repeat (2) @(negedge clk_sys);

    // CPU slow to grant: stall holds for 20 cycles with no memory access
    pause_ack = 1'b0;
    do_rd(25'h0030, t);
    c0 = 0;
    repeat (20) begin
      @(negedge clk_sys);
      if (ioctl_wait && !mem_rd) c0++;
    end
    chk("grant_stall_cycles", 32'(c0), 32'd20);
    k = cyc;
    pause_ack = 1'b1;
    exp_maddr_q.push_back(16'h0030); exp_mcyc_q.push_back(k + 1);
    exp_q.push_back(8'h96); exp_wlen_q.push_back((k + 4) - (t + 1));
    wait_drain(40);

    // strobe during LAT sets overrun; the first read still completes
    do_rd(25'h0040, t);
    exp_q.push_back(8'h5E); exp_wlen_q.push_back(4);
    exp_maddr_q.push_back(16'h0040); exp_mcyc_q.push_back(t + 2);
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("lat_state", 32'(o_dbg_state), 32'(LAT));
    ioctl_rd = 1'b1; ioctl_addr = 25'h0050;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    chk("overrun_set", 32'(overrun), 32'h1);
    wait_drain(40);
    chk("overrun_sticky", 32'(overrun), 32'h1);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    chk("overrun_cleared", 32'(overrun), 32'h0);
    repeat (2) @(negedge clk_sys);

    // session drops during LAT: abort, keep din, pause held until data time
    do_rd(25'h0060, t);
    exp_maddr_q.push_back(16'h0060); exp_mcyc_q.push_back(t + 2);
    @(negedge clk_sys);
    @(negedge clk_sys);
    abort_ok = 1'b1;
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    chk("abort_state", 32'(o_dbg_state), 32'(IDLE));
    chk("abort_wait", 32'(ioctl_wait), 32'h0);
    chk("abort_din", 32'(ioctl_din), 32'h5E);
    chk("abort_pause_held", 32'(pause_req), 32'h1);
    @(negedge clk_sys);
    chk("abort_pause_released", 32'(pause_req), 32'h0);
    chk("abort_din_kept", 32'(ioctl_din), 32'h5E);

    // reset while waiting for grant
    ioctl_upload = 1'b1; pause_ack = 1'b0;
    @(negedge clk_sys);
    do_rd(25'h0070, t);
    chk("grant_state", 32'(o_dbg_state), 32'(GRANT));
    reset = 1'b1;
    @(negedge clk_sys);
    chk_reset_vals("mid_reset");
    reset = 1'b0;
    pause_ack = 1'b1;
    c0 = mrd_count;
    repeat (10) @(negedge clk_sys);
    chk("post_reset_no_mem_rd", 32'(mrd_count), 32'(c0));
    chk("post_reset_state", 32'(o_dbg_state), 32'(IDLE));
    chk("post_reset_wait", 32'(ioctl_wait), 32'h0);

    chk("exp_q_left", 32'(exp_q.size()), 32'd0);
    chk("exp_maddr_q_left", 32'(exp_maddr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ioctl_upload_server.md
# ioctl_upload_server

Serves HPS upload (core-to-HPS) reads on the `hps_io` ioctl bus. It is the mirror of the ROM/DIP download path: the HPS issues `ioctl_rd` strobes with an address, and this block fetches the byte from a core memory port, stalls the HPS with `ioctl_wait`, and presents the byte on `ioctl_din`. It sits between `hps_io` and a secondary port of a core RAM or ROM. While an upload is active it requests a CPU pause so that memory contents are stable, for example NVRAM dumps or ROM readback for verification.

## Interface
Parameters:
- `INDEX`, 8'd2: `ioctl_index` value this block answers to.
- `ADDR_W`, 16: memory address width.
- `LENGTH`, 16'h1000: number of valid bytes; addresses ≥ LENGTH read as FILL.
- `FILL`, 8'hFF: byte returned for out-of-range addresses.
- `READ_LAT`, 2: memory read latency in cycles (1..4), from `mem_rd` to valid `mem_rdata`.

Ports:
- `clk_sys`  in  1  system clock. Single clock domain; everything is synchronous to it.
- `reset`  in  1  synchronous, active-high reset.
- `ioctl_upload`  in  1  HPS upload session active.
- `ioctl_index`  in  8  session index.
- `ioctl_rd`  in  1  one-cycle read strobe from HPS.
- `ioctl_addr`  in  25  byte address, valid with `ioctl_rd`.
- `ioctl_din`  out  8  byte returned to HPS.
- `ioctl_wait`  out  1  HPS stall. The HPS holds off the next `ioctl_rd` while this is high.
- `pause_req`  out  1  request that the core CPU halt.
- `pause_ack`  in  1  the core is halted and the memory port is free.
- `mem_rd`  out  1  one-cycle read strobe.
- `mem_addr`  out  ADDR_W  read address.
- `mem_rdata`  in  8  read data, valid READ_LAT cycles after `mem_rd`.
- `overrun`  out  1  sticky flag: `ioctl_rd` arrived while busy. Cleared by reset or by a new session.

## Operation
- `sel = ioctl_upload & (ioctl_index == INDEX)`.
- `pause_req` is registered `sel`. It is dropped when `sel` falls, but not before any in-flight memory read completes.
- States:
  - IDLE: waiting for a read strobe.
  - GRANT: waiting for `pause_ack`.
  - ISSUE: pulse `mem_rd`.
  - LAT: count READ_LAT cycles.
  - DONE: return data.
- IDLE, when `sel & ioctl_rd`:
  - Latch `ioctl_addr[ADDR_W-1:0]` and set `ioctl_wait`.
  - If `ioctl_addr ≥ LENGTH`, including any nonzero bits above ADDR_W: load FILL into `ioctl_din` and go to DONE.
  - Otherwise go to GRANT.
- GRANT → ISSUE when `pause_ack` is high. The block stays in GRANT indefinitely otherwise.
- ISSUE: `mem_rd` = 1 for exactly one cycle, `mem_addr` = latched address, then go to LAT.
- LAT: a counter loads READ_LAT-1 and decrements. At 0, capture `mem_rdata` into `ioctl_din` and go to DONE.
- DONE: clear `ioctl_wait` and go to IDLE.
- `ioctl_rd` in any state other than IDLE is ignored and sets `overrun`.
- `sel` falling in any state is an abort:
  - Go to IDLE and clear `ioctl_wait`.
  - If the state was LAT, the pending data is discarded.
  - `ioctl_din` keeps its last value.
- Rising edge of `sel` clears `overrun`.

## Timing
- Reset values: `ioctl_din` = 0, `ioctl_wait` = 0, `pause_req` = 0, `mem_rd` = 0, `mem_addr` = 0, `overrun` = 0, state = IDLE.
- Reset mid-read drops everything the next cycle; no `mem_rd` is issued after reset is asserted.
- `ioctl_wait` rises in cycle T+1 after the `ioctl_rd` at cycle T.
- In-range read with `pause_ack` already high:
  - `mem_rd` at T+2.
  - Data captured at T+2+READ_LAT.
  - `ioctl_wait` falls at T+3+READ_LAT, with `ioctl_din` valid in the same cycle.
  - With READ_LAT = 2, `ioctl_wait` is high for 4 cycles.
- Out-of-range read: `ioctl_wait` is high for exactly 1 cycle (T+1); FILL is valid at T+2.
- Address wrap: none. Address LENGTH-1 is valid and LENGTH is FILL.
- Reads are strictly one outstanding at a time.

## Structure
- Shared package `slap_io_pkg`:
  - `upload_state_t` enum (IDLE, GRANT, ISSUE, LAT, DONE).
  - ioctl index constants: ROM = 0, MOD = 1, UPLOAD = 2, DIP = 254.
- Sub-module `rd_lat_counter`: a loadable down-counter with a zero flag, parameterised by READ_LAT width. The rest of the block stays flat.

## Test plan
- Reset, then `sel` with `pause_ack` = 1, READ_LAT = 2, and memory[0x0010] = 0xA5; `ioctl_rd` at addr 0x10 → `mem_rd` at T+2 with `mem_addr` = 0x0010, `ioctl_din` = 0xA5 and `ioctl_wait` falling at T+5.
- Read at addr 0x1000 and at 0x01_0000 with LENGTH = 0x1000 → no `mem_rd`, `ioctl_din` = 0xFF, `ioctl_wait` high for 1 cycle.
- `pause_ack` held low for 20 cycles after `ioctl_rd` → `ioctl_wait` stays high and `mem_rd` stays 0; raise `pause_ack` → `mem_rd` the next cycle and completion 3 cycles later.
- Second `ioctl_rd` while in LAT → `overrun` = 1, first read completes with the correct byte; a new upload session clears `overrun`.
- `ioctl_upload` dropped during LAT → next cycle IDLE, `ioctl_wait` = 0, `ioctl_din` unchanged; `pause_req` falls after the read latency expires.
- Reset asserted in GRANT → next cycle all outputs are at their reset values and no `mem_rd` follows.
